// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit: one outstanding fetch over a valid/ready memory channel,
// hands the word to the decoder, then waits for the next PC. Halts on ebreak, faults on errors.
module ysyx_23060061_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  input  logic        halt,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RESP, S_ISSUE, S_WAITNPC, S_HALT, S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // A misaligned PC never reaches the memory; it faults instead of requesting.
        if (pc_q[1:0] != 2'b00) begin
          state_d    = S_FAULT;
          fault_pc_d = pc_q;
        end else if (imem_req_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_d    = S_FAULT;
            fault_pc_d = pc_q;
          end else begin
            state_d   = S_ISSUE;
            inst_d    = imem_resp_data;
            inst_pc_d = pc_q;
          end
        end
      end
      S_ISSUE: begin
        if (inst_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          if (halt) begin
            state_d = S_HALT;
          end else if (npc_valid) begin
            state_d = S_REQ;
            pc_d    = npc;
          end else begin
            state_d = S_WAITNPC;
          end
        end
      end
      S_WAITNPC: begin
        if (npc_valid) begin
          state_d = S_REQ;
          pc_d    = npc;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inst_q        <= 32'd0;
      inst_pc_q     <= 32'd0;
      fault_pc_q    <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ) && (pc_q[1:0] == 2'b00);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_ISSUE);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign opcode         = inst_q[6:0];
  assign funct3         = inst_q[14:12];
  assign funct7         = inst_q[31:25];
  assign fault          = (state_q == S_FAULT);
  assign fault_pc       = fault_pc_q;
  assign halted         = (state_q == S_HALT);
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// Bench for the fetch unit: a transaction-level model tracks the expected PC and fetch count
// while the bench plays memory and decoder with random delays.
module tb_ysyx_23060061_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        halt;
  logic        npc_valid;
  logic [31:0] npc;
  logic        fault;
  logic [31:0] fault_pc;
  logic        halted;
  logic [31:0] fetch_count;

  int          vectors;
  int          errors;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  ysyx_23060061_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .halt(halt), .npc_valid(npc_valid), .npc(npc),
    .fault(fault), .fault_pc(fault_pc), .halted(halted), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All driving and sampling happens on the falling edge, half a cycle from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_opcode", {25'd0, opcode}, 32'd0);
    check("rst_funct3", {29'd0, funct3}, 32'd0);
    check("rst_funct7", {25'd0, funct7}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_pc", fault_pc, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
  endtask

  // Resets the DUT and releases it; on return the first request should be visible.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    imem_resp_err = 1'b0; inst_ready = 1'b0; halt = 1'b0; npc_valid = 1'b0; npc = 32'd0;
    tick();
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();
    exp_pc    = RESET_PC;
    exp_count = 32'd0;
  endtask

  // One complete fetch transaction as seen from the memory and decoder sides.
  task automatic fetch(input logic [31:0] data, input int req_dly, input int resp_dly,
                       input int iss_dly, input bit err, input bit hlt, input bit same,
                       input int npc_dly, input logic [31:0] next_pc);
    if (exp_pc[1:0] != 2'b00) begin
      check("misalign_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      check("misalign_fault", {31'd0, fault}, 32'd1);
      check("misalign_fault_pc", fault_pc, exp_pc);
      check("misalign_no_req2", {31'd0, imem_req_valid}, 32'd0);
      return;
    end
    check("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, exp_pc);
    for (int i = 0; i < req_dly; i++) begin
      tick();
      check("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
      check("req_hold_addr", imem_req_addr, exp_pc);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("resp_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    for (int i = 0; i < resp_dly; i++) begin
      tick();
      check("resp_wait_no_inst", {31'd0, inst_valid}, 32'd0);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    imem_resp_err   = err;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    imem_resp_data  = $urandom;
    if (err) begin
      check("err_fault", {31'd0, fault}, 32'd1);
      check("err_fault_pc", fault_pc, exp_pc);
      tick();
      check("err_no_req", {31'd0, imem_req_valid}, 32'd0);
      check("err_fault_sticky", {31'd0, fault}, 32'd1);
      return;
    end
    for (int i = 0; i <= iss_dly; i++) begin
      check("issue_valid", {31'd0, inst_valid}, 32'd1);
      check("issue_inst", inst, data);
      check("issue_pc", inst_pc, exp_pc);
      if (i < iss_dly) tick();
    end
    check("issue_opcode", {25'd0, opcode}, {25'd0, data[6:0]});
    check("issue_funct3", {29'd0, funct3}, {29'd0, data[14:12]});
    check("issue_funct7", {25'd0, funct7}, {25'd0, data[31:25]});
    inst_ready = 1'b1;
    halt       = hlt;
    npc_valid  = same;
    npc        = next_pc;
    tick();
    inst_ready = 1'b0;
    halt       = 1'b0;
    npc_valid  = 1'b0;
    exp_count  = exp_count + 32'd1;
    check("fetch_count", fetch_count, exp_count);
    if (hlt) begin
      for (int i = 0; i < 3; i++) begin
        check("halted", {31'd0, halted}, 32'd1);
        check("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
        tick();
      end
      return;
    end
    if (!same) begin
      for (int i = 0; i < npc_dly; i++) begin
        check("waitnpc_no_req", {31'd0, imem_req_valid}, 32'd0);
        check("waitnpc_no_inst", {31'd0, inst_valid}, 32'd0);
        tick();
      end
      npc_valid = 1'b1;
      npc       = next_pc;
      tick();
      npc_valid = 1'b0;
    end
    exp_pc = next_pc;
  endtask

  initial begin
    logic [31:0] nxt;
    vectors = 0;
    errors  = 0;
    do_reset();

    fetch(32'h0010_0093, 0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 32'h8000_0004);
    fetch($urandom, 3, 1, 4, 1'b0, 1'b0, 1'b0, 2, 32'h8000_0100);

    for (int i = 0; i < 30; i++) begin
      nxt = $urandom & 32'hFFFF_FFFC;
      fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 3), nxt);
    end

    $display("[TB] reset while a response is outstanding");
    check("mid_req_valid", {31'd0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    do_reset();

    fetch($urandom, 0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 32'h8000_0008);
    fetch($urandom, 0, 2, 0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    do_reset();

    fetch($urandom, 1, 0, 1, 1'b0, 1'b0, 1'b1, 0, 32'h8000_0102);
    fetch($urandom, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    do_reset();

    $display("[TB] fetch counter wrap with ebreak");
    fetch($urandom, 0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 32'h8000_0004);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    tick();
    release dut.fetch_count_q;
    exp_count = 32'hFFFF_FFFF;
    check("preload_count", fetch_count, exp_count);
    fetch(32'h0010_0073, 0, 0, 0, 1'b0, 1'b1, 1'b1, 0, 32'h8000_0040);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
